// File: rtl/i2c_target_regfile_if.sv
// I2C open-drain bus bundle (scl/sda as _i/_o/_t triplets, _t=1 means released).
//   slave  : target side, consumes scl_i/sda_i and drives the _o/_t pairs
//   master : bus side, drives scl_i/sda_i and observes the _o/_t pairs
interface i2c_target_regfile_if;
    logic scl_i;
    logic scl_o;
    logic scl_t;
    logic sda_i;
    logic sda_o;
    logic sda_t;

    modport slave (
        input  scl_i, sda_i,
        output scl_o, scl_t, sda_o, sda_t
    );

    modport master (
        output scl_i, sda_i,
        input  scl_o, scl_t, sda_o, sda_t
    );
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with a 7-bit bus address and a DEPTH x 8-bit register file behind
// an auto-incrementing register pointer. Writes: addr+W, ptr, data... Reads:
// addr+R streams regs[ptr], regs[ptr+1], ... until the master NACKs.
//
// Ports:
//   clk, rst_n   system clock (>= 10x scl), async active-low reset
//   bus          i2c_target_regfile_if.slave (scl/sda triplets)
//   host_addr    local readback index; host_rdata = regs[host_addr]
//   wr_strobe    one-clk pulse per register written from the bus,
//                with wr_addr / wr_data
//   busy         START seen, no STOP yet
//   addressed    our address was ACKed, no STOP / repeated START yet
//
// Optional build macro I2C_TGT_FILTER_EN: adds a FILTER_LEN-sample stability
// filter on the synchronized scl/sda before edge detection.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for our address
// PTR       | shifting in register pointer
// PTR_ACK   | driving ACK for pointer byte
// WDATA     | shifting in write data
// WDATA_ACK | driving ACK for data byte (register already written)
// RDATA     | shifting out regs[ptr], MSB first
// RDATA_ACK | sda released, sampling master ACK/NACK
// IGNORE    | not for us / read finished; wait for START or STOP
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         FILTER_LEN  = 3,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_target_regfile_if.slave   bus,
    input  logic [AW-1:0]         host_addr,
    output logic [7:0]            host_rdata,
    output logic                  wr_strobe,
    output logic [AW-1:0]         wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  addressed
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t          state, state_n;
    logic [3:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic [AW-1:0]   ptr, ptr_n;
    logic            drv, drv_n;
    logic            addressed_n, busy_n;
    logic            wr_en;
    logic [7:0]      regs [DEPTH];

    // Input synchronizers; idle bus is high so reset to 1.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_flt, sda_flt;
    logic       scl_d, sda_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
        end
    end

`ifdef I2C_TGT_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);
    logic [FCW-1:0] scl_cnt, sda_cnt;

    // A new level is accepted only after FILTER_LEN consecutive samples
    // disagree with the current filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_flt <= 1'b1;
            sda_flt <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_flt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FCW'(FILTER_LEN - 1)) begin
                scl_flt <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_flt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FCW'(FILTER_LEN - 1)) begin
                sda_flt <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN != 0);
    assign scl_flt = scl_sync[1];
    assign sda_flt = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_flt;
            sda_d <= sda_flt;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_flt & ~scl_d;
    assign scl_fall  = ~scl_flt & scl_d;
    assign start_det = scl_flt & scl_d & sda_d & ~sda_flt;
    assign stop_det  = scl_flt & scl_d & ~sda_d & sda_flt;

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        ptr_n       = ptr;
        drv_n       = drv;
        addressed_n = addressed;
        busy_n      = busy;
        wr_en       = 1'b0;

        // Bus conditions win over any scl edge seen in the same cycle.
        if (stop_det) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            drv_n       = 1'b0;
            addressed_n = 1'b0;
            busy_n      = 1'b0;
        end else if (start_det) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            drv_n       = 1'b0;
            addressed_n = 1'b0;
            busy_n      = 1'b1;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_n   = {shreg[6:0], sda_flt};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shreg[7:1] == TARGET_ADDR) begin
                                state_n     = ADDR_ACK;
                                drv_n       = 1'b1;
                                addressed_n = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end else if (state == PTR) begin
                            ptr_n   = shreg[AW-1:0];
                            state_n = PTR_ACK;
                            drv_n   = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_n   = ptr + 1'b1;
                            state_n = WDATA_ACK;
                            drv_n   = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shreg[0]) begin
                            state_n = RDATA;
                            shreg_n = regs[ptr];
                            drv_n   = ~regs[ptr][7];
                        end else begin
                            state_n = PTR;
                            drv_n   = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_n = WDATA;
                        drv_n   = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_n   = RDATA_ACK;
                        bit_cnt_n = '0;
                        drv_n     = 1'b0;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        shreg_n = {shreg[6:0], 1'b0};
                        drv_n   = ~shreg[6];
                    end
                end
                RDATA_ACK: begin
                    // bit_cnt=1 marks "master ACKed" until the 9th fall.
                    if (scl_rise) begin
                        ptr_n = ptr + 1'b1;
                        if (!sda_flt) begin
                            bit_cnt_n = 4'd1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_n   = RDATA;
                        bit_cnt_n = '0;
                        shreg_n   = regs[ptr];
                        drv_n     = ~regs[ptr][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            drv       <= 1'b0;
            addressed <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            ptr       <= ptr_n;
            drv       <= drv_n;
            addressed <= addressed_n;
            busy      <= busy_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= wr_en;
            if (wr_en) begin
                regs[ptr] <= shreg;
                wr_addr   <= ptr;
                wr_data   <= shreg;
            end
        end
    end

    assign host_rdata = regs[host_addr];

    // drv resets asynchronously, so reset releases sda immediately.
    assign bus.sda_t = ~drv;
    assign bus.sda_o = 1'b0;
    assign bus.scl_o = 1'b0;
    assign bus.scl_t = 1'b1;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C master on an
// open-drain bus model, expected values hand-computed per step.
module tb_i2c_target_regfile;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] host_addr = '0;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       addressed;
    logic       bus_sda;

    int cmp_cnt = 0;
    int err_cnt = 0;

    int         stb_n = 0;
    logic [3:0] stb_addr [16];
    logic [7:0] stb_data [16];

    i2c_target_regfile_if bus_if ();

    assign bus_sda      = m_sda & (bus_if.sda_t | bus_if.sda_o);
    assign bus_if.sda_i = bus_sda;
    assign bus_if.scl_i = m_scl & (bus_if.scl_t | bus_if.scl_o);

    i2c_target_regfile #(
        .TARGET_ADDR (7'h50),
        .DEPTH       (16),
        .FILTER_LEN  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .addressed  (addressed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (stb_n < 16) begin
                stb_addr[stb_n] = wr_addr;
                stb_data[stb_n] = wr_data;
            end
            stb_n = stb_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1;
        repeat (4) @(negedge clk);
        b = bus_sda;
        repeat (4) @(negedge clk);
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        send_bits(d);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic host_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        chk(tag, host_rdata, exp);
    endtask

`ifdef I2C_TGT_FILTER_EN
    // Data bit with a 1-clk inverted spike on sda while scl is high.
    task automatic send_bit_glitch(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1;
        repeat (3) @(negedge clk);
        m_sda = ~b;
        @(negedge clk);
        m_sda = b;
        repeat (4) @(negedge clk);
        m_scl = 1'b0; wait_q();
    endtask
`endif

    initial begin
        logic       ack;
        logic [7:0] d;
        int         n0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sda_t", bus_if.sda_t, 1'b1);
        chk("rst_sda_o", bus_if.sda_o, 1'b0);
        chk("rst_scl_o", bus_if.scl_o, 1'b0);
        chk("rst_scl_t", bus_if.scl_t, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addressed", addressed, 1'b0);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 8'h00);
        host_chk("rst_reg0", 4'h0, 8'h00);
        rst_n = 1'b1;
        wait_q();

        // Write 0x50: ptr 3, A5, 5A
        i2c_start();
        chk("w1_busy", busy, 1'b1);
        send_byte(8'hA0, ack); chk("w1_ack_addr", ack, 1'b1);
        chk("w1_addressed", addressed, 1'b1);
        send_byte(8'h03, ack); chk("w1_ack_ptr", ack, 1'b1);
        send_byte(8'hA5, ack); chk("w1_ack_d0", ack, 1'b1);
        send_byte(8'h5A, ack); chk("w1_ack_d1", ack, 1'b1);
        i2c_stop();
        chk("w1_busy_stop", busy, 1'b0);
        chk("w1_addressed_stop", addressed, 1'b0);
        host_chk("w1_reg3", 4'h3, 8'hA5);
        host_chk("w1_reg4", 4'h4, 8'h5A);
        chk("w1_stb_n", stb_n, 2);
        chk("w1_stb0_addr", stb_addr[0], 4'h3);
        chk("w1_stb0_data", stb_data[0], 8'hA5);
        chk("w1_stb1_addr", stb_addr[1], 4'h4);
        chk("w1_stb1_data", stb_data[1], 8'h5A);

        // ptr 2, repeated START, read 2 bytes (ACK, NACK)
        i2c_start();
        send_byte(8'hA0, ack); chk("r1_ack_addr", ack, 1'b1);
        send_byte(8'h02, ack); chk("r1_ack_ptr", ack, 1'b1);
        i2c_start();
        chk("r1_addressed_sr", addressed, 1'b0);
        chk("r1_busy_sr", busy, 1'b1);
        send_byte(8'hA1, ack); chk("r1_ack_raddr", ack, 1'b1);
        read_byte(d, 1'b1); chk("r1_byte0", d, 8'h00);
        read_byte(d, 1'b0); chk("r1_byte1", d, 8'hA5);
        chk("r1_sda_rel", bus_if.sda_t, 1'b1);
        i2c_stop();
        chk("r1_stb_n", stb_n, 2);

        // Pointer left at 4: fresh read without pointer write
        i2c_start();
        send_byte(8'hA1, ack); chk("r2_ack_addr", ack, 1'b1);
        read_byte(d, 1'b0); chk("r2_byte0", d, 8'h5A);
        i2c_stop();

        // Wrong address 0x51
        i2c_start();
        send_byte(8'hA2, ack); chk("na_ack_addr", ack, 1'b0);
        chk("na_addressed", addressed, 1'b0);
        chk("na_busy", busy, 1'b1);
        send_byte(8'h77, ack); chk("na_ack_data", ack, 1'b0);
        i2c_stop();
        chk("na_busy_stop", busy, 1'b0);
        chk("na_stb_n", stb_n, 2);

        // Pointer wrap 15 -> 0
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        send_byte(8'h11, ack); chk("wr_ack_d0", ack, 1'b1);
        send_byte(8'h22, ack); chk("wr_ack_d1", ack, 1'b1);
        i2c_stop();
        host_chk("wr_reg15", 4'hF, 8'h11);
        host_chk("wr_reg0", 4'h0, 8'h22);
        chk("wr_stb2_addr", stb_addr[2], 4'hF);
        chk("wr_stb3_addr", stb_addr[3], 4'h0);
        chk("wr_stb3_data", stb_data[3], 8'h22);

        // Pointer byte 0x1F keeps only the low 4 bits
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h1F, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        read_byte(d, 1'b0); chk("pm_byte0", d, 8'h11);
        i2c_stop();

        // Reset during data-byte ACK
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        send_bits(8'hC3);
        chk("ra_sda_ack", bus_if.sda_t, 1'b0);
        host_chk("ra_reg5_pre", 4'h5, 8'hC3);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_sda_rel", bus_if.sda_t, 1'b1);
        chk("ra_busy", busy, 1'b0);
        chk("ra_addressed", addressed, 1'b0);
        host_chk("ra_reg5", 4'h5, 8'h00);
        host_chk("ra_reg3", 4'h3, 8'h00);
        host_chk("ra_reg15", 4'hF, 8'h00);
        @(negedge clk);
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_q();
        rst_n = 1'b1;
        wait_q();

        // Recovery after reset
        n0 = stb_n;
        i2c_start();
        send_byte(8'hA0, ack); chk("rc_ack_addr", ack, 1'b1);
        send_byte(8'h01, ack);
        send_byte(8'h3C, ack); chk("rc_ack_d0", ack, 1'b1);
        i2c_stop();
        host_chk("rc_reg1", 4'h1, 8'h3C);
        chk("rc_stb_n", stb_n - n0, 1);
        chk("rc_stb_addr", wr_addr, 4'h1);
        chk("rc_stb_data", wr_data, 8'h3C);

`ifdef I2C_TGT_FILTER_EN
        // Glitches on every bit of the data byte must not look like START/STOP
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h06, ack);
        for (int i = 7; i >= 0; i--) send_bit_glitch(i[0] ? 1'b1 : 1'b0);
        recv_bit(ack);
        chk("fl_ack", ack, 1'b0);
        chk("fl_busy", busy, 1'b1);
        chk("fl_addressed", addressed, 1'b1);
        i2c_stop();
        host_chk("fl_reg6", 4'h6, 8'hAA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Synthesizable I2C target that sits on the far side of the bus from the master and consumes the open-drain bus signals (scl/sda, `_i`/`_o`/`_t` tristate triplets, `_t`=1 means released).
- Implements a 7-bit addressed register file with an 8-bit register pointer and auto-increment.
- Serves as the DUT-side counterpart the bridge talks to in system simulation, and as a synthesizable peripheral.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address the block responds to.
- DEPTH, 16, number of 8-bit registers; power of two, 2..256.
- FILTER_LEN, 3, consecutive stable clk samples needed to accept a new scl/sda level. Used only with I2C_TGT_FILTER_EN.

Ports:
- clk  in  1  system clock, at least 10x the scl frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  bus scl input.
- scl_o  out  1  scl output; tied 0.
- scl_t  out  1  scl tristate; tied 1, no clock stretching.
- sda_i  in  1  bus sda input.
- sda_o  out  1  sda output; always 0 (open drain).
- sda_t  out  1  sda tristate; 0 pulls the line low.
- host_addr  in  $clog2(DEPTH)  local register readback address.
- host_rdata  out  8  combinational regs[host_addr].
- wr_strobe  out  1  one-cycle pulse per register written from the bus.
- wr_addr  out  $clog2(DEPTH)  register index for wr_strobe.
- wr_data  out  8  data for wr_strobe.
- busy  out  1  high from START to STOP, whichever target is addressed.
- addressed  out  1  high from address ACK until STOP or repeated START.

Behaviour:
- Input conditioning:
  - scl_i/sda_i pass through a 2-flop synchronizer; edges are detected on the synchronized values.
  - Sync plus edge detect adds 2 clk latency.
- Bus conditions:
  - START: sda falls while scl high. Accepted in any state: goes to ADDR, bit count 0, sda released.
  - STOP: sda rises while scl high. From any state goes to IDLE, sda released, addressed=0.
- Bit timing:
  - sda is sampled on the scl rising edge.
  - sda_t changes only on the scl falling edge (plus 2-cycle sync delay).
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - ADDR: shift 8 bits. On match with TARGET_ADDR, drive ACK (sda_t=0) from the 8th scl fall to the 9th scl fall, then:
    - R/W=0 goes to PTR.
    - R/W=1 goes to RDATA: load shift register from regs[ptr] and drive its MSB from the 9th scl fall.
    - On mismatch goes to IGNORE, which waits for START or STOP.
  - PTR: 8 bits into ptr; only the low $clog2(DEPTH) bits are kept. ACK always. Then WDATA.
  - WDATA: 8 bits, then:
    - regs[ptr] <= byte.
    - wr_strobe pulses for 1 clk with the pre-increment ptr.
    - ptr increments.
    - ACK is driven.
  - RDATA: shift out MSB first. After the 8th bit, release sda and sample master ACK on the 9th scl rise:
    - ACK (sda=0): ptr increments, next byte is loaded, stay in RDATA.
    - NACK: ptr increments, go to IGNORE.
- ptr wraps modulo DEPTH: DEPTH-1 +1 becomes 0.
- ptr persists across transactions, so a repeated START read returns data from the pointer just written.
- Outputs, by drive condition:
  - sda_t=0 only during a driven ACK, or a read data bit equal to 0.
- Reset values:
  - sda_t=1, sda_o=0, scl_o=0, scl_t=1.
  - wr_strobe=0, wr_addr=0, wr_data=0, busy=0, addressed=0, ptr=0, all regs=8'h00, state IDLE.
  - Reset asserted mid-transfer releases sda immediately (asynchronously).
- Simultaneous events: a START/STOP detected in the same clk as an scl edge takes priority.

Optional Feature:
- Macro I2C_TGT_FILTER_EN.
- Defined: each synchronized input passes a FILTER_LEN-sample stability filter before edge detection. Pulses shorter than FILTER_LEN clk are ignored. Added latency is FILTER_LEN clk.
- Undefined: no filter, and FILTER_LEN is unused.

Test Plan:
- Write 0x50 W, ptr 0x03, data 0xA5, 0x5A, STOP -> regs[3]=A5, regs[4]=5A, two wr_strobe pulses (addr 3 and 4), ACK on all 4 bytes.
- Write ptr 0x02, repeated START, read 0x50 R for 2 bytes (ACK then NACK) -> bus returns regs[2], regs[3]; final ptr=4; sda released after NACK.
- Address 0x51 W -> NACK (sda stays high on 9th clock), no wr_strobe, addressed=0, busy=1 until STOP.
- DEPTH=16, ptr 0x0F, write 0x11, 0x22 -> regs[15]=11, regs[0]=22 (wrap).
- rst_n low during ACK of data byte -> sda_t=1 within the same cycle, state IDLE, regs cleared.
- With I2C_TGT_FILTER_EN, 1-clk sda glitch while scl high -> no START/STOP detected, transfer completes correctly.
